// File: rtl/mod_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with clear, load, enable,
// a combinational terminal-count for cascading, and registered overflow/match flags.
module mod_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] cmp_val_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic             match_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             match_q, match_d;
    logic             boundary;

    always_comb begin
        boundary = up_i ? (q_q == MAX_VAL) : (q_q == '0);
        q_d      = q_q;
        ovf_d    = 1'b0;
        if (clr_i) begin
            q_d = RST_VAL;
        end else if (load_i) begin
            // Out-of-range loads clamp to the top so the state stays legal.
            q_d = ({1'b0, load_val_i} >= MOD_EXT) ? MAX_VAL : load_val_i;
        end else if (en_i) begin
            if (boundary) begin
                ovf_d = 1'b1;
                if (WRAP != 0) begin
                    q_d = up_i ? '0 : MAX_VAL;
                end
            end else begin
                q_d = up_i ? (q_q + 1'b1) : (q_q - 1'b1);
            end
        end
        // Compare against the next value so match_o lines up with q_o.
        match_d = (q_d == cmp_val_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= RST_VAL;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            match_q <= match_d;
        end
    end

    assign q_o     = q_q;
    assign ovf_o   = ovf_q;
    assign match_o = match_q;
    assign tc_o    = ~reset & en_i & ~clr_i & ~load_i & boundary;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a wrapping decade counter, a saturating
// decade counter and a two-digit cascade, all on one clock and reset.
module tb_mod_updown_counter;

    logic clk;
    logic reset;

    int n_vec;
    int n_err;

    // wrapping instance
    logic       m_clr, m_load, m_en, m_up;
    logic [3:0] m_lv, m_cmp, m_q;
    logic       m_tc, m_ovf, m_match;

    // saturating instance
    logic       s_clr, s_load, s_en, s_up;
    logic [3:0] s_lv, s_cmp, s_q;
    logic       s_tc, s_ovf, s_match;

    // cascade
    logic       c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_ovf, hi_ovf, lo_match, hi_match;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1), .RESET_VAL(0)) u_main (
        .clk(clk), .reset(reset), .clr_i(m_clr), .load_i(m_load), .load_val_i(m_lv),
        .en_i(m_en), .up_i(m_up), .cmp_val_i(m_cmp), .q_o(m_q), .tc_o(m_tc),
        .ovf_o(m_ovf), .match_o(m_match)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(0), .RESET_VAL(0)) u_sat (
        .clk(clk), .reset(reset), .clr_i(s_clr), .load_i(s_load), .load_val_i(s_lv),
        .en_i(s_en), .up_i(s_up), .cmp_val_i(s_cmp), .q_o(s_q), .tc_o(s_tc),
        .ovf_o(s_ovf), .match_o(s_match)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1), .RESET_VAL(0)) u_lo (
        .clk(clk), .reset(reset), .clr_i(1'b0), .load_i(1'b0), .load_val_i(4'd0),
        .en_i(c_en), .up_i(1'b1), .cmp_val_i(4'd0), .q_o(lo_q), .tc_o(lo_tc),
        .ovf_o(lo_ovf), .match_o(lo_match)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1), .RESET_VAL(0)) u_hi (
        .clk(clk), .reset(reset), .clr_i(1'b0), .load_i(1'b0), .load_val_i(4'd0),
        .en_i(lo_tc), .up_i(1'b1), .cmp_val_i(4'd0), .q_o(hi_q), .tc_o(hi_tc),
        .ovf_o(hi_ovf), .match_o(hi_match)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, wanted finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle to the wrapping counter: tc is checked before the edge,
    // q/ovf/match after it.
    task automatic drive_main(input logic clr, input logic load, input logic en,
                              input logic up, input logic [3:0] lv,
                              input int exp_q, input int exp_ovf, input int exp_tc);
        m_clr = clr; m_load = load; m_en = en; m_up = up; m_lv = lv;
        #1;
        check("main_tc", int'(m_tc), exp_tc);
        @(posedge clk);
        #1;
        check("main_q", int'(m_q), exp_q);
        check("main_ovf", int'(m_ovf), exp_ovf);
        check("main_match", int'(m_match), int'(exp_q == int'(m_cmp)));
    endtask

    task automatic drive_sat(input logic load, input logic en, input logic up,
                             input logic [3:0] lv,
                             input int exp_q, input int exp_ovf, input int exp_tc);
        s_clr = 1'b0; s_load = load; s_en = en; s_up = up; s_lv = lv;
        #1;
        check("sat_tc", int'(s_tc), exp_tc);
        @(posedge clk);
        #1;
        check("sat_q", int'(s_q), exp_q);
        check("sat_ovf", int'(s_ovf), exp_ovf);
        check("sat_match", int'(s_match), int'(exp_q == int'(s_cmp)));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        m_clr = 0; m_load = 0; m_en = 0; m_up = 0; m_lv = 0; m_cmp = 4'd5;
        s_clr = 0; s_load = 0; s_en = 0; s_up = 0; s_lv = 0; s_cmp = 4'd0;
        c_en = 0;

        // Test 1: reset, then count up through the wrap
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", int'(m_q), 0);
        check("rst_ovf", int'(m_ovf), 0);
        check("rst_match", int'(m_match), 0);
        check("rst_sat_q", int'(s_q), 0);
        m_en = 1; m_up = 0;
        #1;
        check("rst_tc_forced", int'(m_tc), 0);
        reset = 1'b0;
        #1;
        check("tc_down_at_0", int'(m_tc), 1);
        for (int i = 1; i <= 11; i++)
            drive_main(0, 0, 1, 1, 4'd0, i % 10, int'(i == 10), int'(i == 10));

        // Test 2: load 7, up across the wrap, then down across it
        m_cmp = 4'd8;
        drive_main(0, 1, 0, 0, 4'd7, 7, 0, 0);
        drive_main(0, 0, 1, 1, 4'd0, 8, 0, 0);
        drive_main(0, 0, 1, 1, 4'd0, 9, 0, 0);
        drive_main(0, 0, 1, 1, 4'd0, 0, 1, 1);
        drive_main(0, 0, 1, 0, 4'd0, 9, 1, 1);
        drive_main(0, 0, 1, 0, 4'd0, 8, 0, 0);
        drive_main(0, 0, 1, 0, 4'd0, 7, 0, 0);
        drive_main(0, 0, 1, 0, 4'd0, 6, 0, 0);
        drive_main(0, 0, 0, 0, 4'd0, 6, 0, 0);

        // Test 4: priorities and clamp
        m_cmp = 4'd12;
        drive_main(1, 1, 1, 1, 4'd5, 0, 0, 0);
        drive_main(1, 0, 1, 0, 4'd0, 0, 0, 0);
        drive_main(0, 1, 0, 0, 4'd13, 9, 0, 0);
        drive_main(0, 1, 1, 1, 4'd3, 3, 0, 0);
        m_cmp = 4'd9;
        drive_main(0, 1, 0, 0, 4'd15, 9, 0, 0);
        drive_main(0, 0, 0, 1, 4'd0, 9, 0, 0);

        // Test 3: saturating counter holds at both bounds
        drive_sat(1, 0, 0, 4'd9, 9, 0, 0);
        for (int i = 0; i < 3; i++)
            drive_sat(0, 1, 1, 4'd0, 9, 1, 1);
        drive_sat(1, 0, 0, 4'd0, 0, 0, 0);
        drive_sat(0, 1, 0, 4'd0, 0, 1, 1);
        drive_sat(0, 1, 0, 4'd0, 0, 1, 1);
        drive_sat(0, 0, 0, 4'd0, 0, 0, 0);

        // Test 6: asynchronous reset drops a pending ovf and clears match
        m_cmp = 4'd6;
        drive_main(0, 1, 0, 0, 4'd9, 9, 0, 0);
        drive_main(0, 0, 1, 1, 4'd0, 0, 1, 1);
        #2 reset = 1'b1;
        #1;
        check("async_q", int'(m_q), 0);
        check("async_ovf_drop", int'(m_ovf), 0);
        check("async_tc", int'(m_tc), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive_main(0, 1, 0, 0, 4'd6, 6, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_q6", int'(m_q), 0);
        check("async_match", int'(m_match), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive_main(0, 0, 1, 1, 4'd0, 1, 0, 0);
        m_en = 0;

        // Test 5: two-digit cascade from 00
        check("chain_start_lo", int'(lo_q), 0);
        check("chain_start_hi", int'(hi_q), 0);
        c_en = 1;
        for (int i = 1; i <= 99; i++) begin
            @(posedge clk);
            #1;
            check("chain_lo", int'(lo_q), i % 10);
            check("chain_hi", int'(hi_q), i / 10);
        end
        check("chain_hi_tc", int'(hi_tc), 1);
        @(posedge clk);
        #1;
        check("chain_wrap_lo", int'(lo_q), 0);
        check("chain_wrap_hi", int'(hi_q), 0);
        check("chain_hi_ovf", int'(hi_ovf), 1);
        check("chain_lo_ovf", int'(lo_ovf), 1);
        @(posedge clk);
        #1;
        check("chain_after_lo", int'(lo_q), 1);
        check("chain_hi_ovf_clear", int'(hi_ovf), 0);
        c_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
